// File: rtl/xpb_seq_ctrl_if.sv
// Bus bundle between the xpb lookup sequencer, its requester and the shared ROM bank.
// The slave modport is the sequencer side; the master modport is the requester/ROM side.
interface xpb_seq_ctrl_if #(
  parameter int NUM_SEG = 8,
  parameter int SEG_W   = 5,
  parameter int DATA_W  = 1024,
  parameter int ACC_W   = 1028
);
  localparam int SEL_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  logic                     start;
  logic [NUM_SEG*SEG_W-1:0] upper_in;
  logic                     ready;
  logic                     busy;
  logic [SEL_W-1:0]         rom_sel;
  logic [SEG_W-1:0]         rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic [ACC_W-1:0]         sum_out;
  logic                     done;

  modport slave (
    input  start, upper_in, rom_data,
    output ready, busy, rom_sel, rom_addr, sum_out, done
  );

  modport master (
    output start, upper_in, rom_data,
    input  ready, busy, rom_sel, rom_addr, sum_out, done
  );
endinterface

// File: rtl/xpb_seq_ctrl.sv
// Time-multiplexed xpb lookup sequencer: walks one registered ROM bank through the
// segments of a product's upper bits and accumulates the returned constants.
module xpb_seq_ctrl #(
  parameter int NUM_SEG = 8,
  parameter int SEG_W   = 5,
  parameter int DATA_W  = 1024,
  parameter int ACC_W   = 1028,
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  xpb_seq_ctrl_if.slave bus
);
  localparam int SEL_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  if (NUM_SEG < 1) begin : g_bad_num_seg
    $error("xpb_seq_ctrl: NUM_SEG must be >= 1");
  end
  if (ROM_LAT < 1) begin : g_bad_rom_lat
    $error("xpb_seq_ctrl: ROM_LAT must be >= 1");
  end
  if (ACC_W < DATA_W + $clog2(NUM_SEG)) begin : g_bad_acc_w
    $error("xpb_seq_ctrl: ACC_W too small for NUM_SEG accumulations of DATA_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_issue;
  logic [SEG_W-1:0]   r_seg [NUM_SEG];
  logic [SEL_W-1:0]   r_cnt;
  // Stage 0 lines up with the registered address, stage ROM_LAT with rom_data.
  logic [ROM_LAT:0]   r_vpipe;
  logic [ACC_W-1:0]   r_acc;
  logic [SEL_W-1:0]   r_rom_sel;
  logic [SEG_W-1:0]   r_rom_addr;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        if (r_cnt == SEL_W'(NUM_SEG - 1)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Nothing behind the final stage means this edge performs the last accumulate.
        if (r_vpipe[ROM_LAT-1:0] == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_vpipe    <= '0;
      r_acc      <= '0;
      r_rom_sel  <= '0;
      r_rom_addr <= '0;
      for (int i = 0; i < NUM_SEG; i++) begin
        r_seg[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);
      r_vpipe <= {r_vpipe[ROM_LAT-1:0], w_issue};

      if (w_accept) begin
        r_cnt <= '0;
        r_acc <= '0;
        for (int i = 0; i < NUM_SEG; i++) begin
          r_seg[i] <= bus.upper_in[i*SEG_W +: SEG_W];
        end
      end else begin
        if (r_vpipe[ROM_LAT]) begin
          r_acc <= r_acc + ACC_W'(bus.rom_data);
        end
        if (w_issue) begin
          r_rom_sel  <= r_cnt;
          r_rom_addr <= r_seg[r_cnt];
          r_cnt      <= r_cnt + SEL_W'(1);
        end
      end
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rom_sel  = r_rom_sel;
  assign bus.rom_addr = r_rom_addr;
  assign bus.sum_out  = r_acc;
endmodule

// File: tb/tb_xpb_seq_ctrl.sv
// Randomised and directed bench for xpb_seq_ctrl, with a transaction-timeline model of
// the expected outputs and a registered ROM returning ((sel+1)<<16)|addr.
module tb_xpb_seq_ctrl;
  localparam int NUM_SEG = 8;
  localparam int SEG_W   = 5;
  localparam int DATA_W  = 1024;
  localparam int ACC_W   = 1028;
  localparam int ROM_LAT = 1;
  localparam int UW      = NUM_SEG * SEG_W;
  localparam int LAST_D  = NUM_SEG + ROM_LAT + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  xpb_seq_ctrl_if #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  xpb_seq_ctrl #(
    .NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.rom_data <= DATA_W'((32'(bus.rom_sel) + 32'd1) << 16) | DATA_W'(bus.rom_addr);
  end

  // Model: m_d counts edges since the accepting edge (-1 when no operation is tracked).
  int               m_d = -1;
  int               m_seg [NUM_SEG];
  int               m_sel = 0;
  int               m_addr = 0;
  logic [ACC_W-1:0] m_sum = '0;
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  bit               m_ready = 1'b1;

  task automatic chk(input string nm, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit st, input logic [UW-1:0] up, input bit rn);
    int i;
    if (!rn) begin
      m_d = -1; m_sel = 0; m_addr = 0; m_sum = '0;
      m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b1;
    end else begin
      if (m_ready && st) begin
        m_d   = 0;
        m_sum = '0;
        for (int k = 0; k < NUM_SEG; k++) m_seg[k] = int'((up >> (k * SEG_W)) & UW'(31));
      end else if (m_d >= 0) begin
        m_d++;
      end
      if (m_d >= 1 && m_d <= NUM_SEG) begin
        m_sel  = m_d - 1;
        m_addr = m_seg[m_d - 1];
      end
      if (m_d >= ROM_LAT + 2 && m_d <= LAST_D) begin
        i = m_d - ROM_LAT - 2;
        m_sum = m_sum + ACC_W'(((i + 1) << 16) | m_seg[i]);
      end
      m_busy  = (m_d >= 0) && (m_d < LAST_D);
      m_done  = (m_d == LAST_D);
      m_ready = !m_busy;
      if (m_d > LAST_D) m_d = -1;
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic cycle(input bit st, input logic [UW-1:0] up, input bit rn);
    bus.start    = st;
    bus.upper_in = up;
    rst_n        = rn;
    @(posedge clk);
    model_edge(st, up, rn);
    #1;
    chk("ready",    ACC_W'(bus.ready),    ACC_W'(m_ready));
    chk("busy",     ACC_W'(bus.busy),     ACC_W'(m_busy));
    chk("done",     ACC_W'(bus.done),     ACC_W'(m_done));
    chk("rom_sel",  ACC_W'(bus.rom_sel),  ACC_W'(m_sel));
    chk("rom_addr", ACC_W'(bus.rom_addr), ACC_W'(m_addr));
    chk("sum_out",  bus.sum_out,          m_sum);
  endtask

  task automatic run_op(input logic [UW-1:0] up, input int noise_at, input logic [ACC_W-1:0] exp_sum);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    cycle(1'b1, up, 1'b1);
    chk("acc_clear", bus.sum_out, ACC_W'(0));
    for (int k = 1; k <= 30 && !seen; k++) begin
      cycle(noise_at == k, (noise_at == k) ? ~up : up, 1'b1);
      if (bus.done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk("done_latency", ACC_W'(lat), ACC_W'(10));
    chk("final_sum", bus.sum_out, exp_sum);
  endtask

  initial begin
    int dcnt;
    bus.start    = 1'b0;
    bus.upper_in = '0;
    rst_n        = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0);
    chk("rst_ready", ACC_W'(bus.ready), ACC_W'(1));
    chk("rst_sum",   bus.sum_out,       ACC_W'(0));
    cycle(1'b0, '0, 1'b1);

    run_op(40'h0, 0, ACC_W'(32'h240000));
    run_op(40'h00_000F_8000, 0, ACC_W'(32'h24001F));
    run_op(40'hFF_FFFF_FFFF, 0, ACC_W'(32'h2400F8));
    run_op(40'h0, 0, ACC_W'(32'h240000));
    cycle(1'b0, '0, 1'b1);
    run_op(40'h00_000F_8000, 3, ACC_W'(32'h24001F));
    cycle(1'b0, '0, 1'b1);

    cycle(1'b1, 40'hFF_FFFF_FFFF, 1'b1);
    for (int k = 1; k <= 4; k++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("midrst_busy",  ACC_W'(bus.busy),  ACC_W'(0));
    chk("midrst_ready", ACC_W'(bus.ready), ACC_W'(1));
    chk("midrst_done",  ACC_W'(bus.done),  ACC_W'(0));
    chk("midrst_sum",   bus.sum_out,       ACC_W'(0));
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      cycle(1'b0, '0, 1'b1);
      if (bus.done) dcnt++;
    end
    chk("no_done_after_rst", ACC_W'(dcnt), ACC_W'(0));
    run_op(40'hFF_FFFF_FFFF, 0, ACC_W'(32'h2400F8));

    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 3) == 0, UW'({$urandom, $urandom}), $urandom_range(0, 80) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
